dispatch_ctrl: RTL and testbench

- Sequencing and flow-control stage wrapped around the combinational dispatch steering network.
- Accepts one renamed group of up to DISPATCH_WIDTH micro-ops per cycle.
- Admits a group only when every target issue queue (INT/MEM/FP) has enough free entries, tracked with per-queue credit counters. Admitted groups are registered into the steering network.
- Handles pipeline flush with a one-cycle recovery state, and counts stall cycles for performance analysis.

---
 rtl/dispatch_ctrl_if.sv | 38 +++
 rtl/dispatch_ctrl.sv | 114 +++++++++++
 tb/tb_dispatch_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_ctrl_if.sv
// Micro-op types shared by dispatch stages, plus the group handshake interface
// between the rename stage and the dispatch controller.
package dispatch_pkg;
  localparam int DISPATCH_WIDTH = 4;

  typedef enum logic [1:0] {
    IQ_NONE = 2'd0,
    IQ_INT  = 2'd1,
    IQ_MEM  = 2'd2,
    IQ_FP   = 2'd3
  } iq_code_e;

  typedef struct packed {
    logic     valid;
    iq_code_e iq_code;
    logic [15:0] payload;
  } micro_op_t;
endpackage

interface dispatch_if #(parameter int W = dispatch_pkg::DISPATCH_WIDTH);
  import dispatch_pkg::*;

  micro_op_t [W-1:0] uop_in;
  logic              uop_in_valid;
  logic              uop_in_ready;
  micro_op_t [W-1:0] uop_out;
  logic              uop_out_valid;

  modport master (
    output uop_in, uop_in_valid,
    input  uop_in_ready, uop_out, uop_out_valid
  );

  modport slave (
    input  uop_in, uop_in_valid,
    output uop_in_ready, uop_out, uop_out_valid
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch flow control: credit-gated group admission into the steering register,
// flush recovery and stall-cycle accounting.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int DISPATCH_WIDTH = dispatch_pkg::DISPATCH_WIDTH,
  parameter int IQ_INT_SIZE    = 16,
  parameter int IQ_MEM_SIZE    = 16,
  parameter int IQ_FP_SIZE     = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_flush,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0] i_int_freed,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0] i_mem_freed,
  input  logic [$clog2(DISPATCH_WIDTH+1)-1:0] i_fp_freed,
  dispatch_if.slave                           io_disp,
  output logic [31:0]                         o_stall_cycles,
  output logic                                o_credit_err
);
  localparam int FW    = $clog2(DISPATCH_WIDTH + 1);
  localparam int MAXSZ = (IQ_INT_SIZE > IQ_MEM_SIZE)
                         ? ((IQ_INT_SIZE > IQ_FP_SIZE) ? IQ_INT_SIZE : IQ_FP_SIZE)
                         : ((IQ_MEM_SIZE > IQ_FP_SIZE) ? IQ_MEM_SIZE : IQ_FP_SIZE);
  localparam int CW    = $clog2(MAXSZ + 1);
  localparam int SW    = CW + 1;

  typedef enum logic [0:0] {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cred_int, r_cred_mem, r_cred_fp;
  micro_op_t [DISPATCH_WIDTH-1:0] r_uop_out;
  logic                          r_uop_out_valid;
  logic [31:0]                   r_stall_cycles;
  logic                          r_credit_err;

  logic [FW-1:0] w_n_int, w_n_mem, w_n_fp;
  logic          w_ready, w_fire, w_stall, w_run;
  logic [SW-1:0] w_sum_int, w_sum_mem, w_sum_fp;
  logic          w_ovf_int, w_ovf_mem, w_ovf_fp;

  always_comb begin
    w_n_int = '0;
    w_n_mem = '0;
    w_n_fp  = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (io_disp.uop_in[i].valid) begin
        case (io_disp.uop_in[i].iq_code)
          IQ_INT:  w_n_int = w_n_int + FW'(1);
          IQ_MEM:  w_n_mem = w_n_mem + FW'(1);
          IQ_FP:   w_n_fp  = w_n_fp  + FW'(1);
          default: ;
        endcase
      end
    end
  end

  assign w_run   = (r_state == RUN) && !i_flush;
  assign w_ready = w_run
                   && (SW'(w_n_int) <= SW'(r_cred_int))
                   && (SW'(w_n_mem) <= SW'(r_cred_mem))
                   && (SW'(w_n_fp)  <= SW'(r_cred_fp));
  assign w_fire  = io_disp.uop_in_valid && w_ready;
  assign w_stall = w_run && io_disp.uop_in_valid && !w_ready;

  // Fire implies n <= credit, so the subtraction never wraps.
  assign w_sum_int = SW'(r_cred_int) - (w_fire ? SW'(w_n_int) : SW'(0)) + SW'(i_int_freed);
  assign w_sum_mem = SW'(r_cred_mem) - (w_fire ? SW'(w_n_mem) : SW'(0)) + SW'(i_mem_freed);
  assign w_sum_fp  = SW'(r_cred_fp)  - (w_fire ? SW'(w_n_fp)  : SW'(0)) + SW'(i_fp_freed);
  assign w_ovf_int = w_sum_int > SW'(IQ_INT_SIZE);
  assign w_ovf_mem = w_sum_mem > SW'(IQ_MEM_SIZE);
  assign w_ovf_fp  = w_sum_fp  > SW'(IQ_FP_SIZE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= RUN;
      r_cred_int      <= CW'(IQ_INT_SIZE);
      r_cred_mem      <= CW'(IQ_MEM_SIZE);
      r_cred_fp       <= CW'(IQ_FP_SIZE);
      r_uop_out       <= '0;
      r_uop_out_valid <= 1'b0;
      r_stall_cycles  <= '0;
      r_credit_err    <= 1'b0;
    end else begin
      r_uop_out_valid <= w_fire;
      if (w_fire) r_uop_out <= io_disp.uop_in;
      if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;

      case (r_state)
        RUN:     if (i_flush) r_state <= RECOVER;
        RECOVER: if (!i_flush) r_state <= RUN;
        default: r_state <= RUN;
      endcase

      // Flushed queues are empty, and releases are ignored outside RUN.
      if (i_flush) begin
        r_cred_int <= CW'(IQ_INT_SIZE);
        r_cred_mem <= CW'(IQ_MEM_SIZE);
        r_cred_fp  <= CW'(IQ_FP_SIZE);
      end else if (r_state == RUN) begin
        r_cred_int <= w_ovf_int ? CW'(IQ_INT_SIZE) : CW'(w_sum_int);
        r_cred_mem <= w_ovf_mem ? CW'(IQ_MEM_SIZE) : CW'(w_sum_mem);
        r_cred_fp  <= w_ovf_fp  ? CW'(IQ_FP_SIZE)  : CW'(w_sum_fp);
        if (w_ovf_int || w_ovf_mem || w_ovf_fp) r_credit_err <= 1'b1;
      end
    end
  end

  assign io_disp.uop_in_ready  = w_ready;
  assign io_disp.uop_out       = r_uop_out;
  assign io_disp.uop_out_valid = r_uop_out_valid;
  assign o_stall_cycles        = r_stall_cycles;
  assign o_credit_err          = r_credit_err;
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: admission, credit exhaustion/refill,
// flush recovery, credit overflow and asynchronous reset.
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  localparam int W = DISPATCH_WIDTH;
  typedef micro_op_t [W-1:0] group_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  int_freed = '0;
  logic [2:0]  mem_freed = '0;
  logic [2:0]  fp_freed = '0;
  logic [31:0] stall_cycles;
  logic        credit_err;
  int          checks = 0;
  int          errors = 0;

  dispatch_if u_if();

  dispatch_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_int_freed    (int_freed),
    .i_mem_freed    (mem_freed),
    .i_fp_freed     (fp_freed),
    .io_disp        (u_if),
    .o_stall_cycles (stall_cycles),
    .o_credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  // Slot codes: I/M/F valid uop for that queue, N valid no-queue uop,
  // x invalid INT slot, '-' empty slot.
  function automatic group_t grp(input string s, input logic [15:0] base);
    group_t g;
    g = '0;
    for (int i = 0; i < W; i++) begin
      g[i].payload = base + 16'(i);
      case (s[i])
        "I": begin g[i].valid = 1'b1; g[i].iq_code = IQ_INT;  end
        "M": begin g[i].valid = 1'b1; g[i].iq_code = IQ_MEM;  end
        "F": begin g[i].valid = 1'b1; g[i].iq_code = IQ_FP;   end
        "N": begin g[i].valid = 1'b1; g[i].iq_code = IQ_NONE; end
        "x": begin g[i].valid = 1'b0; g[i].iq_code = IQ_INT;  end
        default: g[i] = '0;
      endcase
    end
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    flush = 1'b0;
    int_freed = '0; mem_freed = '0; fp_freed = '0;
    u_if.uop_in_valid = 1'b0;
    u_if.uop_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input group_t g);
    u_if.uop_in = g;
    u_if.uop_in_valid = 1'b1;
    tick();
    u_if.uop_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (u_if.uop_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", u_if.uop_out_valid); end
    checks++; if (u_if.uop_out !== group_t'(0)) begin errors++; $display("FAIL reset_uop_out got %h exp 0", u_if.uop_out); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", credit_err); end
    checks++; if ({dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp} !== {5'd16, 5'd16, 5'd16}) begin errors++;
      $display("FAIL reset_credits got %0d/%0d/%0d exp 16/16/16", dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp); end
    checks++; if (u_if.uop_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", u_if.uop_in_ready); end
  endtask

  task automatic test_basic();
    group_t g;
    apply_reset();
    g = grp("IIMF", 16'h0100);
    u_if.uop_in = g;
    u_if.uop_in_valid = 1'b1;
    #1;
    checks++; if (u_if.uop_in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", u_if.uop_in_ready); end
    tick();
    u_if.uop_in_valid = 1'b0;
    checks++; if (u_if.uop_out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", u_if.uop_out_valid); end
    checks++; if (u_if.uop_out !== g) begin errors++; $display("FAIL basic_uop_out got %h exp %h", u_if.uop_out, g); end
    checks++; if ({dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp} !== {5'd14, 5'd15, 5'd15}) begin errors++;
      $display("FAIL basic_credits got %0d/%0d/%0d exp 14/15/15", dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp); end
    u_if.uop_in = grp("MMMM", 16'h0200);
    tick();
    checks++; if (u_if.uop_out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b exp 0", u_if.uop_out_valid); end
    checks++; if (u_if.uop_out !== g) begin errors++; $display("FAIL basic_hold got %h exp %h", u_if.uop_out, g); end
    // All-empty group (and no-queue uops) still fire without touching credits.
    send(grp("N---", 16'h0300));
    checks++; if (u_if.uop_out_valid !== 1'b1) begin errors++; $display("FAIL basic_empty_fire got %b exp 1", u_if.uop_out_valid); end
    checks++; if ({dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp} !== {5'd14, 5'd15, 5'd15}) begin errors++;
      $display("FAIL basic_empty_credits got %0d/%0d/%0d exp 14/15/15", dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp); end
  endtask

  task automatic test_back_to_back();
    group_t g5;
    apply_reset();
    for (int k = 0; k < 4; k++) send(grp("IIII", 16'(16'h1000 + 16 * k)));
    checks++; if (dut.r_cred_int !== 5'd0) begin errors++; $display("FAIL b2b_exhaust got %0d exp 0", dut.r_cred_int); end
    checks++; if (u_if.uop_out !== grp("IIII", 16'h1030)) begin errors++; $display("FAIL b2b_last_out got %h exp %h", u_if.uop_out, grp("IIII", 16'h1030)); end
    g5 = grp("IIII", 16'h1040);
    u_if.uop_in = g5;
    u_if.uop_in_valid = 1'b1;
    #1;
    checks++; if (u_if.uop_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got %b exp 0", u_if.uop_in_ready); end
    tick();
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL b2b_stall1 got %0d exp 1", stall_cycles); end
    tick();
    checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL b2b_stall2 got %0d exp 2", stall_cycles); end
    int_freed = 3'd1;
    tick();
    int_freed = 3'd0;
    checks++; if (dut.r_cred_int !== 5'd1) begin errors++; $display("FAIL b2b_freed1_cred got %0d exp 1", dut.r_cred_int); end
    checks++; if (u_if.uop_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_freed1_ready got %b exp 0", u_if.uop_in_ready); end
    int_freed = 3'd3;
    tick();
    int_freed = 3'd0;
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL b2b_stall4 got %0d exp 4", stall_cycles); end
    checks++; if (u_if.uop_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_refill_ready got %b exp 1", u_if.uop_in_ready); end
    tick();
    u_if.uop_in_valid = 1'b0;
    checks++; if (u_if.uop_out_valid !== 1'b1 || u_if.uop_out !== g5) begin errors++; $display("FAIL b2b_fire got %b/%h exp 1/%h", u_if.uop_out_valid, u_if.uop_out, g5); end
    checks++; if (dut.r_cred_int !== 5'd0 || stall_cycles !== 32'd4) begin errors++; $display("FAIL b2b_after got cred %0d stall %0d exp 0/4", dut.r_cred_int, stall_cycles); end
  endtask

  task automatic test_independent();
    apply_reset();
    for (int k = 0; k < 4; k++) send(grp("IIII", 16'h2000));
    u_if.uop_in = grp("MMMM", 16'h2100);
    u_if.uop_in_valid = 1'b1;
    #1;
    checks++; if (u_if.uop_in_ready !== 1'b1) begin errors++; $display("FAIL indep_mem_ready got %b exp 1", u_if.uop_in_ready); end
    tick();
    checks++; if (dut.r_cred_mem !== 5'd12) begin errors++; $display("FAIL indep_mem_cred got %0d exp 12", dut.r_cred_mem); end
    u_if.uop_in = grp("xMMM", 16'h2200);
    #1;
    checks++; if (u_if.uop_in_ready !== 1'b1) begin errors++; $display("FAIL indep_invalid_ready got %b exp 1", u_if.uop_in_ready); end
    tick();
    u_if.uop_in_valid = 1'b0;
    checks++; if ({dut.r_cred_int, dut.r_cred_mem} !== {5'd0, 5'd9}) begin errors++; $display("FAIL indep_credits got %0d/%0d exp 0/9", dut.r_cred_int, dut.r_cred_mem); end
    checks++; if (u_if.uop_out !== grp("xMMM", 16'h2200)) begin errors++; $display("FAIL indep_out got %h", u_if.uop_out); end
  endtask

  task automatic test_flush();
    string plan [8] = '{"IIII", "IIII", "IIII", "IMMM", "MMMM", "MMFF", "FFFF", "F---"};
    group_t g;
    apply_reset();
    foreach (plan[k]) send(grp(plan[k], 16'h3000));
    checks++; if ({dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp} !== {5'd3, 5'd7, 5'd9}) begin errors++;
      $display("FAIL flush_pre_credits got %0d/%0d/%0d exp 3/7/9", dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp); end
    g = grp("I---", 16'h3100);
    u_if.uop_in = g;
    u_if.uop_in_valid = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (u_if.uop_in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", u_if.uop_in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (dut.r_state !== 1'b1) begin errors++; $display("FAIL flush_state got %b exp 1", dut.r_state); end
    checks++; if (u_if.uop_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", u_if.uop_out_valid); end
    checks++; if (u_if.uop_in_ready !== 1'b0) begin errors++; $display("FAIL recover_ready got %b exp 0", u_if.uop_in_ready); end
    checks++; if ({dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp} !== {5'd16, 5'd16, 5'd16}) begin errors++;
      $display("FAIL flush_credits got %0d/%0d/%0d exp 16/16/16", dut.r_cred_int, dut.r_cred_mem, dut.r_cred_fp); end
    int_freed = 3'd1;
    tick();
    int_freed = 3'd0;
    checks++; if (dut.r_state !== 1'b0 || u_if.uop_out_valid !== 1'b0) begin errors++; $display("FAIL recover_exit got state %b valid %b exp 0/0", dut.r_state, u_if.uop_out_valid); end
    checks++; if (dut.r_cred_int !== 5'd16 || credit_err !== 1'b0) begin errors++; $display("FAIL recover_freed got cred %0d err %b exp 16/0", dut.r_cred_int, credit_err); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL recover_stall got %0d exp 0", stall_cycles); end
    tick();
    u_if.uop_in_valid = 1'b0;
    checks++; if (u_if.uop_out_valid !== 1'b1 || u_if.uop_out !== g) begin errors++; $display("FAIL post_flush_fire got %b/%h exp 1/%h", u_if.uop_out_valid, u_if.uop_out, g); end
    checks++; if (dut.r_cred_int !== 5'd15) begin errors++; $display("FAIL post_flush_cred got %0d exp 15", dut.r_cred_int); end
  endtask

  task automatic test_overflow();
    apply_reset();
    int_freed = 3'd2;
    tick();
    int_freed = 3'd0;
    checks++; if (dut.r_cred_int !== 5'd16) begin errors++; $display("FAIL ovf_saturate got %0d exp 16", dut.r_cred_int); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", credit_err); end
    repeat (3) tick();
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", credit_err); end
    apply_reset();
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", credit_err); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) send(grp("IIII", 16'h4000));
    u_if.uop_in = grp("IIII", 16'h4100);
    u_if.uop_in_valid = 1'b1;
    repeat (5) tick();
    u_if.uop_in = grp("MMMM", 16'h4200);
    tick();
    checks++; if (u_if.uop_out_valid !== 1'b1 || stall_cycles !== 32'd5) begin errors++; $display("FAIL areset_pre got valid %b stall %0d exp 1/5", u_if.uop_out_valid, stall_cycles); end
    #2 rst = 1'b1;
    #1;
    checks++; if (u_if.uop_out_valid !== 1'b0 || u_if.uop_out !== group_t'(0)) begin errors++; $display("FAIL areset_out got %b/%h exp 0/0", u_if.uop_out_valid, u_if.uop_out); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL areset_stall got %0d exp 0", stall_cycles); end
    checks++; if ({dut.r_cred_int, dut.r_cred_mem} !== {5'd16, 5'd16}) begin errors++; $display("FAIL areset_credits got %0d/%0d exp 16/16", dut.r_cred_int, dut.r_cred_mem); end
    u_if.uop_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    u_if.uop_in = '0;
    u_if.uop_in_valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_independent();
    test_flush();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
